// File: rtl/sevenseg_scan_if.sv
// Update handshake between a display-data source and sevenseg_scan.
// The source drives req/wdata/wdp; the scanner answers with a one-cycle ack.
interface sevenseg_scan_if #(
  parameter int NDIG = 4
);
  logic              req;
  logic [4*NDIG-1:0] wdata;
  logic [NDIG-1:0]   wdp;
  logic              ack;

  modport master (output req, wdata, wdp, input ack);
  modport slave  (input req, wdata, wdp, output ack);
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Shadow data is only replaced at frame boundaries, so a frame never mixes old and new digits.
module sevenseg_scan #(
  parameter int NDIG = 4,
  parameter int DIV  = 1000,
  parameter int DEAD = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  sevenseg_scan_if.slave      bus,
  input  logic                lzb,
  output logic [3:0]          hex,
  output logic [NDIG-1:0]     ndig,
  output logic                ndp,
  output logic                frame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic              run_reg;
  logic [4*NDIG-1:0] sdata_reg, sdata_next;
  logic [NDIG-1:0]   sdp_reg, sdp_next;
  logic              boundary;

  logic [3:0]        hex_reg, hex_next;
  logic [NDIG-1:0]   ndig_reg, ndig_next;
  logic              ndp_reg, ndp_next;
  logic              ack_reg, frame_reg;
  logic              suppress, lit;

  logic [3:0]        nib [NDIG];
  logic [NDIG-1:0]   nz;
  logic [NDIG-1:0]   hi_zero;

  // State register. run_reg makes the first edge after reset a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      run_reg   <= 1'b0;
      sdata_reg <= '0;
      sdp_reg   <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      run_reg   <= 1'b1;
      sdata_reg <= sdata_next;
      sdp_reg   <= sdp_next;
    end
  end

  // Next-state logic
  always_comb begin
    boundary   = ~run_reg | ((cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST));
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    sdata_next = sdata_reg;
    sdp_next   = sdp_reg;
    if (!run_reg) begin
      cnt_next = '0;
      idx_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
    if (boundary && bus.req) begin
      sdata_next = bus.wdata;
      sdp_next   = bus.wdp;
    end
  end

  // hi_zero[i]: digits i..NDIG-1 of the incoming shadow value are all zero
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    assign nib[gi]     = sdata_next[4*gi +: 4];
    assign nz[gi]      = |nib[gi];
    assign hi_zero[gi] = ~|nz[NDIG-1:gi];
  end

  // Outputs are computed from next state and registered, so they describe the cycle being entered
  always_comb begin
    suppress = lzb && (idx_next != '0) && hi_zero[idx_next];
    lit      = (cnt_next >= DEAD_C) && !suppress;
    hex_next = nib[idx_next];
    ndp_next = ~(lit & sdp_next[idx_next]);
    for (int i = 0; i < NDIG; i++) begin
      ndig_next[i] = ~(lit && (idx_next == IW'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_reg   <= '0;
      ndig_reg  <= '1;
      ndp_reg   <= 1'b1;
      ack_reg   <= 1'b0;
      frame_reg <= 1'b0;
    end else begin
      hex_reg   <= hex_next;
      ndig_reg  <= ndig_next;
      ndp_reg   <= ndp_next;
      ack_reg   <= boundary & bus.req;
      frame_reg <= boundary;
    end
  end

  assign bus.ack = ack_reg;
  assign hex     = hex_reg;
  assign ndig    = ndig_reg;
  assign ndp     = ndp_reg;
  assign frame   = frame_reg;

endmodule
